fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch stage between a variable-latency instruction memory and the pipelined core's F/D register.
- Issues in-order word fetches, reserves a queue slot per request, and fills slots as responses return.
- Presents the oldest filled instruction with its PC to decode under a valid/ready handshake.
- Flushes on a branch/jump redirect and silently drops responses still in flight.

Parameters:
DEPTH, 4, queue slots (power of two, >=2); bounds requests in flight plus buffered instructions
RESET_PC, 32'h0, first fetch address after reset
CNT_W, $clog2(DEPTH)+1, width of occupancy/drop counters

Ports:
clock  in  1  master clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  new fetch address
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address (PC)
imem_resp_valid  in  1  in-order response strobe
imem_resp_data  in  32  instruction word
fd_valid  out  1  head slot filled
fd_ready  in  1  decode can accept (core's ~stall)
fd_instr  out  32  head instruction
fd_pc  out  32  head instruction address
fd_pc_plus1  out  32  fd_pc+1, modulo 2^32, for link/branch base
occupancy  out  CNT_W  allocated slots (filled + awaiting response)
proto_err  out  1  sticky: response arrived with no request pending

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, head=tail=0, all slots invalid/unfilled, drop=0, proto_err=0.
  - fd_valid, imem_req_valid and occupancy are 0.
  - fd_instr, fd_pc and fd_pc_plus1 are 0 while the queue is empty.
- Slot state: {allocated, filled, pc, instr}.
  - Allocate at tail on request handshake (imem_req_valid & imem_req_ready); slot pc=fetch_pc.
  - fetch_pc increments by 1, wrapping at 2^32.
- Issue rule: imem_req_valid = ~redirect_valid & (occupancy + drop < DEPTH). Combinational, no dependence on imem_req_ready.
- Responses are strictly in order.
  - If drop!=0: discard the response and decrement drop.
  - Else: write the response into the oldest allocated-unfilled slot and set filled.
- Decode side:
  - fd_valid = head slot allocated & filled; fd_* driven combinationally from the head slot.
  - Pop when fd_valid & fd_ready.
  - Latency: a response accepted at edge N appears on fd_valid after edge N; zero-wait imem gives one instruction per cycle after a 2-cycle startup.
- Full queue (occupancy=DEPTH): no requests. A pop and a request in the same cycle are both allowed.
- Empty queue: fd_valid=0; fd_ready is ignored.
- Redirect (sampled at rising edge):
  - All slots are invalidated.
  - drop_next = drop + unfilled_count − (resp consumed this cycle ? 1 : 0).
  - fetch_pc = redirect_pc; no request is issued in the redirect cycle; the first request for redirect_pc is issued the next cycle.
  - A pop in the same cycle counts as transferred.
  - Redirect has priority over response fill and over allocation.
- Back-to-back redirects: drop accumulates. It is bounded by DEPTH through the issue rule.
- Unsolicited response (drop=0 and no unfilled slot): data is ignored and proto_err sets.

Decomposition:
- Shared package fetch_pkg holds:
  - constants FETCH_DEPTH and RESET_PC;
  - the slot struct typedef {alloc, filled, pc[31:0], instr[31:0]};
  - pointer-width localparam helpers.
- One natural sub-module, fetch_slot_array:
  - DEPTH-entry slot storage;
  - tail (alloc), fill and head pointers with wrap-around;
  - unfilled_count output.
- Issue, drop and handshake logic stays in fetch_queue.

Test Plan:
- Zero-wait imem (req_ready=1, resp one cycle later), fd_ready=1, program 0..7 → fd_pc 0,1,2,… on consecutive cycles after startup; fd_instr matches; occupancy ≤2.
- fd_ready=0 for 10 cycles → exactly DEPTH=4 requests (PCs 0–3), then imem_req_valid=0; releasing fd_ready drains PCs 0,1,2,3 in order with no loss.
- 3-cycle resp latency, redirect_valid with redirect_pc=0x40 while 2 responses pending:
  - both late responses are discarded (drop 2→0);
  - the next fd_pc is 0x40 with the correct instr;
  - no fd_valid for stale PCs.
- Redirect in the same cycle as a response and a pop → that response is dropped, the pop counts, drop equals the remaining unfilled count, and fetch restarts at redirect_pc.
- Reset asserted mid-stream with 3 slots filled → outputs clear immediately (async); after release the first imem_req_addr=RESET_PC. A spurious imem_resp_valid while idle → proto_err=1 and stays 1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;
  localparam int FETCH_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic        alloc;
    logic        filled;
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_slot_array.sv
// Circular slot store: allocate at tail, fill in order, pop at head; flush clears all.
// Updates take effect on the next edge; the caller guarantees no alloc when full, no pop when head unfilled.
module fetch_slot_array
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int CNT_W = cntWidth(FETCH_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              allocEn,
  input  logic [31:0]       allocPc,
  input  logic              fillEn,
  input  logic [31:0]       fillData,
  input  logic              popEn,
  output slot_t             headSlot,
  output logic [CNT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  unfilledCount
);
  localparam int PTR_W = ptrWidth(DEPTH);

  slot_t            slots [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W-1:0] fillPtr;

  assign headSlot = slots[headPtr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      headPtr       <= '0;
      tailPtr       <= '0;
      fillPtr       <= '0;
      occupancy     <= '0;
      unfilledCount <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      headPtr       <= '0;
      tailPtr       <= '0;
      fillPtr       <= '0;
      occupancy     <= '0;
      unfilledCount <= '0;
    end else begin
      // Tail, fill and head never coincide on an active slot, so these writes are disjoint.
      if (allocEn) begin
        slots[tailPtr] <= '{alloc: 1'b1, filled: 1'b0, pc: allocPc, instr: 32'h0};
        tailPtr        <= tailPtr + 1'b1;
      end
      if (fillEn) begin
        slots[fillPtr].filled <= 1'b1;
        slots[fillPtr].instr  <= fillData;
        fillPtr               <= fillPtr + 1'b1;
      end
      if (popEn) begin
        slots[headPtr] <= '0;
        headPtr        <= headPtr + 1'b1;
      end
      occupancy     <= occupancy + CNT_W'(allocEn) - CNT_W'(popEn);
      unfilledCount <= unfilledCount + CNT_W'(allocEn) - CNT_W'(fillEn);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// In-order prefetch queue: one request per cycle while slots+drops < DEPTH; fill-to-fd_valid is one edge.
// Decode stalls hold the head; a redirect flushes all slots and drops responses still in flight.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              fd_valid,
  input  logic              fd_ready,
  output logic [31:0]       fd_instr,
  output logic [31:0]       fd_pc,
  output logic [31:0]       fd_pc_plus1,
  output logic [CNT_W-1:0]  occupancy,
  output logic              proto_err
);
  logic [31:0]      fetchPc;
  logic [CNT_W-1:0] dropCnt;
  logic [CNT_W-1:0] unfilledCount;
  logic [CNT_W:0]   inFlight;
  slot_t            headSlot;
  logic             reqFire;
  logic             respDrop;
  logic             respFill;
  logic             respBad;
  logic             pop;

  // Dropped responses still occupy memory bandwidth, so they count against the budget.
  assign inFlight       = {1'b0, occupancy} + {1'b0, dropCnt};
  assign imem_req_valid = reset & ~redirect_valid & (inFlight < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid & imem_req_ready;

  assign respDrop = imem_resp_valid & (dropCnt != '0);
  assign respFill = imem_resp_valid & (dropCnt == '0) & (unfilledCount != '0);
  assign respBad  = imem_resp_valid & (dropCnt == '0) & (unfilledCount == '0);

  assign fd_valid    = headSlot.alloc & headSlot.filled;
  assign fd_instr    = headSlot.alloc ? headSlot.instr : 32'h0;
  assign fd_pc       = headSlot.alloc ? headSlot.pc : 32'h0;
  assign fd_pc_plus1 = headSlot.alloc ? headSlot.pc + 32'd1 : 32'h0;
  assign pop         = fd_valid & fd_ready;

  fetch_slot_array #(.DEPTH(DEPTH), .CNT_W(CNT_W)) slotArray (
    .clock        (clock),
    .reset        (reset),
    .flush        (redirect_valid),
    .allocEn      (reqFire),
    .allocPc      (fetchPc),
    .fillEn       (respFill & ~redirect_valid),
    .fillData     (imem_resp_data),
    .popEn        (pop),
    .headSlot     (headSlot),
    .occupancy    (occupancy),
    .unfilledCount(unfilledCount)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetchPc   <= RESET_PC;
      dropCnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (respBad) proto_err <= 1'b1;
      if (redirect_valid) begin
        // Every unfilled slot becomes a response to discard, less the one arriving now.
        fetchPc <= redirect_pc;
        dropCnt <= dropCnt + unfilledCount - CNT_W'(respDrop | respFill);
      end else begin
        if (reqFire)  fetchPc <= fetchPc + 32'd1;
        if (respDrop) dropCnt <= dropCnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-programmable in-order memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_addr;
  logic             imem_resp_valid;
  logic [31:0]      imem_resp_data;
  logic             fd_valid;
  logic             fd_ready;
  logic [31:0]      fd_instr;
  logic [31:0]      fd_pc;
  logic [31:0]      fd_pc_plus1;
  logic [CNT_W-1:0] occupancy;
  logic             proto_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int fires = 0;
  bit lastFire;
  logic [31:0] lastAddr;
  logic [31:0] pendAddr [$];
  int          pendDue  [$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_instr(fd_instr), .fd_pc(fd_pc),
    .fd_pc_plus1(fd_pc_plus1), .occupancy(occupancy), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record the request handshake, then drive the response due this cycle.
  task automatic tick();
    #1;
    lastFire = imem_req_valid && imem_req_ready;
    lastAddr = imem_req_addr;
    @(posedge clock);
    #1;
    cyc++;
    if (lastFire) begin
      pendAddr.push_back(lastAddr);
      pendDue.push_back(cyc + lat - 1);
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (pendAddr.size() > 0 && pendDue[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = {16'hC0DE, pendAddr[0][15:0]};
      void'(pendAddr.pop_front());
      void'(pendDue.pop_front());
    end
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    pendAddr.delete();
    pendDue.delete();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    cyc = 0;
  endtask

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; fd_ready = 1'b0;
    #2;
    chk("rst_fd_valid", fd_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_fd_pc", fd_pc, 0);
    chk("rst_fd_instr", fd_instr, 0);
    chk("rst_fd_pc_plus1", fd_pc_plus1, 0);
    chk("rst_proto_err", proto_err, 0);

    // Zero-wait stream
    doReset();
    lat = 1; fd_ready = 1'b1;
    chk("a_first_addr", imem_req_addr, 32'h0);
    tick();
    chk("a_startup_valid", fd_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("a_valid", fd_valid, 1);
      chk("a_pc", fd_pc, i);
      chk("a_instr", fd_instr, {16'hC0DE, 16'(i)});
      chk("a_pc_plus1", fd_pc_plus1, i + 1);
      chk("a_occ_le2", (occupancy <= 2), 1);
    end

    // Decode stalled: queue fills to DEPTH then stops requesting
    doReset();
    lat = 1; fd_ready = 1'b0; fires = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (lastFire) begin
        chk("b_req_addr", lastAddr, fires);
        fires++;
      end
    end
    chk("b_fires", fires, 4);
    chk("b_req_valid_full", imem_req_valid, 0);
    chk("b_occ_full", occupancy, 4);
    fd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b_drain_valid", fd_valid, 1);
      chk("b_drain_pc", fd_pc, i);
      tick();
    end

    // Redirect with two responses in flight, 3-cycle memory
    doReset();
    lat = 3; fd_ready = 1'b1;
    tick(); tick();
    chk("c_occ_pre", occupancy, 2);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("c_no_req_in_redirect", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("c_drop2", dut.dropCnt, 2);
    chk("c_occ_flush", occupancy, 0);
    chk("c_req_valid", imem_req_valid, 1);
    chk("c_req_addr", imem_req_addr, 32'h40);
    tick();
    chk("c_stale_valid1", fd_valid, 0);
    chk("c_drop1", dut.dropCnt, 1);
    tick();
    chk("c_stale_valid2", fd_valid, 0);
    chk("c_drop0", dut.dropCnt, 0);
    tick();
    chk("c_stale_valid3", fd_valid, 0);
    tick();
    chk("c_new_valid", fd_valid, 1);
    chk("c_new_pc", fd_pc, 32'h40);
    chk("c_new_instr", fd_instr, 32'hC0DE0040);
    tick();
    chk("c_next_pc", fd_pc, 32'h41);

    // Redirect coinciding with a response and a pop, 2-cycle memory
    doReset();
    lat = 2; fd_ready = 1'b1;
    tick(); tick(); tick();
    chk("d_head_valid", fd_valid, 1);
    chk("d_head_pc", fd_pc, 0);
    chk("d_resp_now", imem_resp_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    #1;
    chk("d_no_req_in_redirect", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("d_drop", dut.dropCnt, 1);
    chk("d_occ", occupancy, 0);
    chk("d_valid_after", fd_valid, 0);
    chk("d_req_addr", imem_req_addr, 32'h80);
    tick();
    chk("d_drop_done", dut.dropCnt, 0);
    chk("d_valid2", fd_valid, 0);
    tick();
    chk("d_valid3", fd_valid, 0);
    tick();
    chk("d_new_valid", fd_valid, 1);
    chk("d_new_pc", fd_pc, 32'h80);
    chk("d_new_instr", fd_instr, 32'hC0DE0080);
    chk("d_new_pc_plus1", fd_pc_plus1, 32'h81);

    // Async reset mid-stream, then an unsolicited response
    doReset();
    lat = 1; fd_ready = 1'b0;
    repeat (4) tick();
    chk("e_occ", occupancy, 4);
    chk("e_valid", fd_valid, 1);
    reset = 1'b0;
    pendAddr.delete();
    pendDue.delete();
    imem_resp_valid = 1'b0;
    #1;
    chk("e_async_valid", fd_valid, 0);
    chk("e_async_occ", occupancy, 0);
    chk("e_async_req", imem_req_valid, 0);
    chk("e_async_pc", fd_pc, 0);
    chk("e_async_instr", fd_instr, 0);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("e_restart_valid", imem_req_valid, 1);
    chk("e_restart_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
    #1;
    chk("e_proto_before", proto_err, 0);
    tick();
    chk("e_proto_set", proto_err, 1);
    repeat (3) tick();
    chk("e_proto_sticky", proto_err, 1);
    chk("e_occ_idle", occupancy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
